halt_monitor: RTL

Cycle-accounting and halt-detection block instantiated inside `soc` beside `cpu`. It observes the fetch/decode boundary and detects the program-end idiom: `jal x0,0` in fetch while decode holds a bubble. It counts run cycles, retired instructions and, optionally, stall cycles. Benches read `halted` and the counters instead of probing pipeline internals.

---
 rtl/halt_monitor_pkg.sv | 13 +
 rtl/sat_counter.sv | 36 +++
 rtl/halt_monitor.sv | 134 +++++++++++++
 3 files changed

// File: rtl/halt_monitor_pkg.sv
// Shared types and instruction constants for the halt monitor.
package halt_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } hm_state_t;

  localparam logic [31:0] RV_JAL_SELF = 32'h0000006F;
  localparam logic [31:0] RV_BUBBLE   = 32'h00000000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags that the next value is all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q   = cnt_q;
  // Reported against the next value so overflow rises on the saturating edge.
  assign sat = &cnt_d;

endmodule

// File: rtl/halt_monitor.sv
// Run-cycle / retirement accounting and program-end (jal x0,0 over a bubble) detection.
// Optional stall counter enabled by defining HALT_MONITOR_STALL_CNT_EN.
module halt_monitor
  import halt_monitor_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          HALT_CONFIRM = 2,
  parameter logic [31:0] HALT_INSTR   = RV_JAL_SELF,
  parameter logic [31:0] BUBBLE_INSTR = RV_BUBBLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_instr,
  input  logic [31:0]      decode_instr,
  input  logic             retire_valid,
  input  logic             stall,
  output logic             halted,
  output logic             halt_pulse,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired,
`ifdef HALT_MONITOR_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cycles,
`endif
  output logic             overflow
);

  localparam int                CONF_W    = $clog2(HALT_CONFIRM + 1);
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(HALT_CONFIRM);

  hm_state_t         state_q, state_d;
  logic [CONF_W-1:0] confirm_q, confirm_d;
  logic              halted_q, halted_d;
  logic              pulse_q, pulse_d;
  logic              ovf_q, ovf_d;
  logic              match, count_edge;
  logic              cyc_sat, ret_sat, stl_sat;

  assign match = fetch_valid && (fetch_instr == HALT_INSTR) && (decode_instr == BUBBLE_INSTR);

  // The IDLE->RUN edge is itself a counted run cycle.
  assign count_edge = (state_q == RUN) || ((state_q == IDLE) && fetch_valid);

  always_comb begin
    state_d   = state_q;
    confirm_d = confirm_q;
    pulse_d   = 1'b0;
    if (clear) begin
      state_d   = IDLE;
      confirm_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          confirm_d = '0;
          if (fetch_valid) state_d = RUN;
        end
        RUN: begin
          if (!match) begin
            confirm_d = '0;
          end else if (confirm_q + 1'b1 == CONF_LAST) begin
            state_d   = HALTED;
            confirm_d = '0;
            pulse_d   = 1'b1;
          end else begin
            confirm_d = confirm_q + 1'b1;
          end
        end
        HALTED:  confirm_d = '0;
        default: begin
          state_d   = IDLE;
          confirm_d = '0;
        end
      endcase
    end
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      confirm_q <= '0;
      halted_q  <= 1'b0;
      pulse_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      confirm_q <= confirm_d;
      halted_q  <= halted_d;
      pulse_q   <= pulse_d;
      ovf_q     <= ovf_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycles (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (count_edge),
    .q   (cycles),
    .sat (cyc_sat)
  );

  sat_counter #(.W(CNT_W)) u_retired (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (count_edge && retire_valid),
    .q   (retired),
    .sat (ret_sat)
  );

`ifdef HALT_MONITOR_STALL_CNT_EN
  sat_counter #(.W(CNT_W)) u_stall (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc ((state_q == RUN) && stall),
    .q   (stall_cycles),
    .sat (stl_sat)
  );
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign stl_sat      = 1'b0;
`endif

  assign ovf_d = clear ? 1'b0 : (ovf_q | cyc_sat | ret_sat | stl_sat);

  assign halted     = halted_q;
  assign halt_pulse = pulse_q;
  assign overflow   = ovf_q;

endmodule
